// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_serializer_pkg
// Shared definitions for word_serializer: FSM state encoding, default word
// width and the even-parity helper used when the parity beat is enabled
// (macro WORD_SERIALIZER_PARITY_EN).
// -----------------------------------------------------------------------------
package word_serializer_pkg;

  // FSM state encoding. The localparam form keeps the encoding compatible with
  // older tools and with the legacy block this one replaces.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Default word width, which matches the pipo_shift output word.
  localparam int DEFAULT_WIDTH = 16;

  // Widest legal word; the parity helper takes words zero-extended to this.
  localparam int MAX_WIDTH = 64;

  // Even parity: the XOR of every bit of the word. Zero-extension leaves the
  // result unchanged.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Takes a WIDTH-bit parallel word over a valid/ready handshake and sends it
// one bit per beat on a serial valid/ready stream. The bit order is set by
// LSB_FIRST. ser_last marks the final beat of each frame. A new word can be
// accepted on the final beat of the current one, so frames follow each other
// with no gap. When ser_ready is low, all state and all outputs hold.
//
// Optional feature (macro WORD_SERIALIZER_PARITY_EN): each frame gets one
// extra beat carrying the even parity of the accepted word. ser_last then
// moves to that parity beat.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   in_data    in   parallel word (WIDTH bits), sampled only on acceptance
//   in_valid   in   in_data is valid
//   in_ready   out  block accepts a word this cycle (combinational)
//   ser_out    out  current serial bit
//   ser_valid  out  ser_out is valid
//   ser_last   out  current beat is the final beat of the frame
//   ser_ready  in   downstream accepts the current beat
//   busy       out  a word is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [WIDTH-1:0] shreg_shifted_s;
  logic             out_bit_s;
  logic             at_last_data_s;
  logic             load_s;

  // The output end of the shift register depends on bit order. A shift moves
  // the next bit into that end and fills the far end with zero.
  assign out_bit_s       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign shreg_shifted_s = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                     : {shreg_q[WIDTH-2:0], 1'b0};

  assign at_last_data_s = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign load_s         = in_valid && in_ready;

  // Upstream ready: always ready when idle. Otherwise ready only on the final
  // beat of the frame, and only if that beat transfers, which allows gapless
  // back-to-back frames. Held low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:   in_ready = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
        ST_SHIFT:  in_ready = 1'b0;
        ST_PARITY: in_ready = ser_ready;
`else
        ST_SHIFT:  in_ready = (cnt_q == CNT_LAST) ? ser_ready : 1'b0;
`endif
        default:   in_ready = 1'b0;
      endcase
    end
  end

  // Serial-side outputs. These are decoded only from registered state, so
  // they cannot change while a beat is stalled.
  always_comb begin
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = out_bit_s;
`ifdef WORD_SERIALIZER_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = at_last_data_s;
`endif
      end
`ifdef WORD_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        ser_valid = 1'b1;
        ser_out   = par_q;
        ser_last  = 1'b1;
      end
`endif
      default: begin
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // Next-state logic for the FSM, the shift register and the beat counter.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef WORD_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d = ST_SHIFT;
          shreg_d = in_data;
          cnt_d   = CNT_ZERO;
`ifdef WORD_SERIALIZER_PARITY_EN
          par_d   = even_parity(MAX_WIDTH'(in_data));
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          shreg_d = shreg_shifted_s;
          cnt_d   = cnt_q + CNT_ONE;
          if (at_last_data_s) begin
`ifdef WORD_SERIALIZER_PARITY_EN
            // The parity beat follows. Hold cnt so it still reads WIDTH-1.
            state_d = ST_PARITY;
            cnt_d   = cnt_q;
`else
            if (load_s) begin
              shreg_d = in_data;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end
`endif
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef WORD_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (ser_ready) begin
          if (load_s) begin
            state_d = ST_SHIFT;
            shreg_d = in_data;
            cnt_d   = CNT_ZERO;
            par_d   = even_parity(MAX_WIDTH'(in_data));
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        shreg_d = {WIDTH{1'b0}};
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers. Reset is synchronous and drops any word in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
// Runs an MSB-first and an LSB-first instance side by side on the same
// stimulus. The reference model holds the beats each instance still owes the
// downstream as a queue of {bit, last} pairs. A frame is pushed when a word is
// accepted, and one beat is popped on each transfer.
// -----------------------------------------------------------------------------
module tb_word_serializer;

  localparam int W = 16;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam bit PAR   = 1'b1;
`else
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = W + (PAR ? 1 : 0);

  typedef logic [1:0] beat_q_t [$];

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         ser_ready = 1'b1;

  logic in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
  logic in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  beat_q_t qm, ql;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
    .ser_last(ser_last_m), .ser_ready(ser_ready), .busy(busy_m));

  word_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .ser_last(ser_last_l), .ser_ready(ser_ready), .busy(busy_l));

  wire [4:0] obs_m = {in_ready_m, ser_valid_m, ser_last_m, busy_m, ser_out_m};
  wire [4:0] obs_l = {in_ready_l, ser_valid_l, ser_last_l, busy_l, ser_out_l};

  // Expected {in_ready, ser_valid, ser_last, busy, ser_out} from the pending beats.
  function automatic logic [4:0] exp_vec(input beat_q_t q, input logic rst_n,
                                         input logic srdy);
    logic v, l, o, rdy;
    v   = (q.size() != 0);
    o   = v ? q[0][1] : 1'b0;
    l   = v ? q[0][0] : 1'b0;
    rdy = rst_n && ((q.size() == 0) || ((q.size() == 1) && srdy));
    return {rdy, v, l, v, o};
  endfunction

  // Advance one clock edge and update the reference model with that edge.
  task automatic tick();
    logic [4:0]   e;
    logic         acc;
    logic [W-1:0] d;
    logic         last;
    e   = exp_vec(qm, reset, ser_ready);
    acc = e[4] && in_valid;
    d   = in_data;
    @(posedge clk);
    if (!reset) begin
      qm.delete();
      ql.delete();
    end else begin
      if (ser_ready && qm.size() != 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          last = (i == W - 1) && !PAR;
          qm.push_back({d[W-1-i], last});
          ql.push_back({d[i], last});
        end
        if (PAR) begin
          qm.push_back({^d, 1'b1});
          ql.push_back({^d, 1'b1});
        end
        acc_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h1234; ser_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      checks++;
      if (obs_m !== 5'b00000) begin
        failures++; $display("FAIL reset_msb cycle %0d got %b want 00000", c, obs_m);
      end
      checks++;
      if (obs_l !== 5'b00000) begin
        failures++; $display("FAIL reset_lsb cycle %0d got %b want 00000", c, obs_l);
      end
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    #1;
    checks++;
    if (obs_m !== 5'b10000) begin
      failures++; $display("FAIL reset_release got %b want 10000", obs_m);
    end
  endtask

  task automatic test_single();
    logic [31:0] cm, cl;
    int beats, lasts, last_at;
    logic [31:0] want_m, want_l;
    cm = '0; cl = '0; beats = 0; lasts = 0; last_at = 0;
    want_m = PAR ? {15'd0, 16'h8E16, 1'b1} : {16'd0, 16'h8E16};
    want_l = PAR ? {15'd0, 16'h6871, 1'b1} : {16'd0, 16'h6871};
    ser_ready = 1'b1; in_valid = 1'b1; in_data = 16'h8E16;
    for (int c = 0; c < FRAME + 3; c++) begin
      #1;
      checks++;
      if (obs_m !== exp_vec(qm, reset, ser_ready)) begin
        failures++; $display("FAIL single_msb cycle %0d got %b want %b", c, obs_m, exp_vec(qm, reset, ser_ready));
      end
      checks++;
      if (obs_l !== exp_vec(ql, reset, ser_ready)) begin
        failures++; $display("FAIL single_lsb cycle %0d got %b want %b", c, obs_l, exp_vec(ql, reset, ser_ready));
      end
      if (ser_valid_m) begin
        beats++;
        cm = {cm[30:0], ser_out_m};
        cl = {cl[30:0], ser_out_l};
        if (ser_last_m) begin lasts++; last_at = beats; end
      end
      tick();
      in_valid = 1'b0; in_data = 16'hFFFF;
    end
    checks++;
    if (cm !== want_m) begin failures++; $display("FAIL single_seq_msb got %h want %h", cm, want_m); end
    checks++;
    if (cl !== want_l) begin failures++; $display("FAIL single_seq_lsb got %h want %h", cl, want_l); end
    checks++;
    if (beats != FRAME || lasts != 1 || last_at != FRAME) begin
      failures++; $display("FAIL single_last beats=%0d lasts=%0d at=%0d want %0d,1,%0d", beats, lasts, last_at, FRAME, FRAME);
    end
    checks++;
    if (busy_m !== 1'b0) begin failures++; $display("FAIL single_idle busy got %b want 0", busy_m); end
  endtask

  task automatic test_back_to_back();
    int beats, gaps, start;
    beats = 0; gaps = 0; start = acc_cnt;
    ser_ready = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      if (acc_cnt == start + 1) in_data = 16'h0001;
      if (acc_cnt >= start + 2) in_valid = 1'b0;
      #1;
      checks++;
      if (obs_m !== exp_vec(qm, reset, ser_ready)) begin
        failures++; $display("FAIL b2b_msb cycle %0d got %b want %b", c, obs_m, exp_vec(qm, reset, ser_ready));
      end
      checks++;
      if (obs_l !== exp_vec(ql, reset, ser_ready)) begin
        failures++; $display("FAIL b2b_lsb cycle %0d got %b want %b", c, obs_l, exp_vec(ql, reset, ser_ready));
      end
      if (ser_valid_m) beats++;
      else if (beats > 0 && beats < 2 * FRAME) gaps++;
      tick();
    end
    checks++;
    if (beats != 2 * FRAME || gaps != 0) begin
      failures++; $display("FAIL b2b_contig beats=%0d gaps=%0d want %0d,0", beats, gaps, 2 * FRAME);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int beats;
    pat = 4'b1001; beats = 0;
    in_valid = 1'b1; in_data = W'($urandom); ser_ready = 1'b1;
    for (int c = 0; c < FRAME + 12; c++) begin
      if (c >= 6 && c < 10) ser_ready = pat[9 - c];
      else ser_ready = (c < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      if (c == 1) in_valid = 1'b0;
      if (c == FRAME + 10) ser_ready = 1'b1;
      #1;
      checks++;
      if (obs_m !== exp_vec(qm, reset, ser_ready)) begin
        failures++; $display("FAIL bp_msb cycle %0d got %b want %b", c, obs_m, exp_vec(qm, reset, ser_ready));
      end
      checks++;
      if (obs_l !== exp_vec(ql, reset, ser_ready)) begin
        failures++; $display("FAIL bp_lsb cycle %0d got %b want %b", c, obs_l, exp_vec(ql, reset, ser_ready));
      end
      if (ser_valid_m && ser_ready) beats++;
      tick();
    end
    ser_ready = 1'b1;
    for (int c = 0; c < FRAME && qm.size() != 0; c++) begin
      if (ser_valid_m) beats++;
      tick();
    end
    checks++;
    if (beats != FRAME) begin failures++; $display("FAIL bp_beats got %0d want %0d", beats, FRAME); end
  endtask

  task automatic test_reset_mid();
    ser_ready = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == 1) in_valid = 1'b0;
      if (c == 6) begin reset = 1'b0; in_valid = 1'b0; end
      if (c == 7) reset = 1'b1;
      if (c == 9) begin in_valid = 1'b1; in_data = 16'h0F0F; end
      if (c == 10) in_valid = 1'b0;
      #1;
      checks++;
      if (obs_m !== exp_vec(qm, reset, ser_ready)) begin
        failures++; $display("FAIL rstmid_msb cycle %0d got %b want %b", c, obs_m, exp_vec(qm, reset, ser_ready));
      end
      checks++;
      if (obs_l !== exp_vec(ql, reset, ser_ready)) begin
        failures++; $display("FAIL rstmid_lsb cycle %0d got %b want %b", c, obs_l, exp_vec(ql, reset, ser_ready));
      end
      if (c == 7) begin
        checks++;
        if (ser_valid_m !== 1'b0) begin failures++; $display("FAIL rstmid_drop got %b want 0", ser_valid_m); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      ser_ready = 1'($urandom_range(0, 3) != 0);
      reset     = 1'($urandom_range(0, 99) != 0);
      #1;
      checks++;
      if (obs_m !== exp_vec(qm, reset, ser_ready)) begin
        failures++; $display("FAIL rand_msb cycle %0d got %b want %b", c, obs_m, exp_vec(qm, reset, ser_ready));
      end
      checks++;
      if (obs_l !== exp_vec(ql, reset, ser_ready)) begin
        failures++; $display("FAIL rand_lsb cycle %0d got %b want %b", c, obs_l, exp_vec(ql, reset, ser_ready));
      end
      tick();
    end
    reset = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
